// File: rtl/aes_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : aes_result_checker
// Description : Captures one AES cipher word via valid/ready and checks it
//               byte-by-byte against a known answer, with verdict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_result_checker #(
    parameter logic [127:0] EXPECTED       = 128'h4b286e22c5d2113d01227cc2cdf88f39,
    parameter int unsigned  TIMEOUT_CYCLES = 1024,
    parameter int unsigned  CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cipher_valid,
    input  logic [127:0]     cipher_in,
    output logic             cipher_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [15:0]      byte_match,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam int unsigned c_WC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WC_W-1:0] c_WAIT_LAST =
        c_WC_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit c_TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WAIT    = 2'd1;
    localparam logic [1:0] c_COMPARE = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [127:0]      r_cap;
    logic [3:0]        r_idx;
    logic [c_WC_W-1:0] r_wait_cnt;
    logic              r_to_flag;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic [15:0]       r_byte_match;
    logic [CNT_W-1:0]  r_pass_cnt;
    logic [CNT_W-1:0]  r_fail_cnt;
    logic              w_timeout_hit;
    logic              w_verdict;
    logic [7:0]        w_cap_byte;
    logic [7:0]        w_exp_byte;

    // Handshake takes priority over the timeout on the same edge.
    assign w_timeout_hit = c_TO_EN && (r_wait_cnt == c_WAIT_LAST) && !cipher_valid;
    assign w_verdict     = (&r_byte_match) && !r_to_flag;
    assign w_cap_byte    = r_cap[{r_idx, 3'b000} +: 8];
    assign w_exp_byte    = EXPECTED[{r_idx, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (start) w_state_nxt = c_WAIT;
            c_WAIT: begin
                if (cipher_valid)       w_state_nxt = c_COMPARE;
                else if (w_timeout_hit) w_state_nxt = c_DONE;
            end
            c_COMPARE: if (r_idx == 4'd15) w_state_nxt = c_DONE;
            c_DONE:    w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap        <= '0;
            r_idx        <= '0;
            r_wait_cnt   <= '0;
            r_to_flag    <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_byte_match <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_byte_match <= '0;
                        r_pass       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_to_flag    <= 1'b0;
                        r_wait_cnt   <= '0;
                    end
                end
                c_WAIT: begin
                    if (cipher_valid) begin
                        r_cap <= cipher_in;
                        r_idx <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WC_W'(1);
                        if (w_timeout_hit) r_to_flag <= 1'b1;
                    end
                end
                c_COMPARE: begin
                    r_byte_match[r_idx] <= (w_cap_byte == w_exp_byte);
                    r_idx               <= r_idx + 4'd1;
                end
                c_DONE: begin
                    r_done    <= 1'b1;
                    r_pass    <= w_verdict;
                    r_timeout <= r_to_flag;
                    if (w_verdict) begin
                        if (r_pass_cnt != c_CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                    end else begin
                        if (r_fail_cnt != c_CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cipher_ready = (r_state == c_WAIT);
    assign busy         = (r_state != c_IDLE);
    assign done         = r_done;
    assign pass         = r_pass;
    assign timeout      = r_timeout;
    assign byte_match   = r_byte_match;
    assign pass_count   = r_pass_cnt;
    assign fail_count   = r_fail_cnt;

endmodule
`default_nettype wire

// File: doc/aes_result_checker.md
Name: aes_result_checker

Overview:
- Downstream consumer of the AES encrypt core's 128-bit cipher output.
- On a start request, waits for a valid cipher word through a valid/ready handshake and captures it.
- Compares the captured word against a known-answer vector one byte per cycle, then reports a per-byte match mask for the board LEDs and a pass/fail verdict.
- Keeps saturating pass/fail counters and flags a timeout if the core never delivers a result.

Parameters:
- EXPECTED, 128'h4b286e22c5d2113d01227cc2cdf88f39, known-answer cipher text; byte k is EXPECTED[8k+7:8k].
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before the check is abandoned; 0 disables the timeout.
- CNT_W, 8, width of the pass and fail counters.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin one check; sampled only in IDLE.
- cipher_valid  input  1  cipher_in holds a valid result.
- cipher_in  input  128  cipher text from the AES core.
- cipher_ready  output  1  checker will accept cipher_in this cycle.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when a verdict is published.
- pass  output  1  last verdict: all 16 bytes matched; held until the next accepted start.
- timeout  output  1  last check was abandoned by timeout; held until the next accepted start.
- byte_match  output  16  bit k = captured byte k equals EXPECTED byte k (LED drive).
- pass_count  output  CNT_W  number of passing checks, saturating.
- fail_count  output  CNT_W  number of failing or timed-out checks, saturating.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state returns to IDLE.
  - All outputs and internal registers go to 0: capture register, byte index, wait counter, byte_match, pass, timeout, done, both counters.
  - Applies mid-operation: any in-flight check is discarded with no done and no counter update.
- FSM states: IDLE, WAIT, COMPARE, DONE.
- IDLE:
  - start=1 -> WAIT; clears byte_match, pass, timeout and the wait counter on the same edge.
  - start outside IDLE is ignored.
- WAIT:
  - cipher_ready = 1 (decoded from the state register only; no combinational path from inputs).
  - On an edge with cipher_valid=1: capture cipher_in, set byte index to 0, go to COMPARE.
  - Otherwise the wait counter increments.
  - If TIMEOUT_CYCLES != 0, wait counter == TIMEOUT_CYCLES-1 and cipher_valid=0: go to DONE with the internal timeout flag set.
  - If the handshake and the timeout condition occur on the same edge, the handshake wins.
- COMPARE:
  - cipher_ready = 0.
  - Each edge sets byte_match[idx] = (cap[8idx+7:8idx] == EXPECTED[8idx+7:8idx]) and increments idx.
  - After idx=15 is written, go to DONE. Exactly 16 cycles in COMPARE.
  - The capture register is not affected by cipher_in changes while in COMPARE.
- DONE, one cycle; on its exit edge:
  - done <= 1 for exactly one cycle.
  - pass <= &byte_match and not timeout.
  - timeout output <= internal timeout flag.
  - pass_count increments on pass; otherwise fail_count increments.
  - Go to IDLE.
- Latency: capture edge E0; byte_match bit k updates at E(k+1); DONE entered at E16; done high from E17 to E18. A start during the done cycle is accepted at E18, and done falls at E18.
- Counters saturate at 2^CNT_W-1 with no wrap.
- Timeout path: byte_match stays 0; a timeout always counts as a fail.
- byte_match, pass and timeout are held stable from DONE until the next accepted start (LEDs remain lit).

Test Plan:
- Match: reset, start, cipher_valid=1 with cipher_in=128'h4b286e22c5d2113d01227cc2cdf88f39 on the first WAIT cycle -> byte_match fills bit 0..15 over 16 cycles; done pulses 17 cycles after capture; pass=1; byte_match=16'hFFFF; pass_count=1; fail_count=0.
- Single-byte error: cipher_in=128'ha71e174fed2f12b172c823be01041f87 -> byte_match=16'h0000, pass=0, fail_count=1. Then cipher_in with only byte 5 changed to 8'h00 -> byte_match=16'hFFDF, pass=0, fail_count=2.
- Handshake/backpressure: hold cipher_valid low for 10 cycles after start, then high -> capture on the first valid edge only; cipher_ready low in IDLE, COMPARE and DONE; start pulses during COMPARE are ignored (no second check).
- Timeout: TIMEOUT_CYCLES=8, start, never assert valid -> DONE after 8 WAIT cycles; timeout=1, pass=0, byte_match=0, fail_count+1. Valid asserted on the 8th WAIT cycle -> normal capture with timeout=0.
- Reset mid-COMPARE: drop rst_n at byte 7 -> all outputs 0 immediately without waiting for clk; no done. After release, a new check runs normally.
- Saturation: CNT_W=2, run 5 passing checks -> pass_count stays at 3.
